// File: rtl/access_entry_ctrl_pkg.sv
// Shared definitions for the access-code entry sequencer: state encoding and
// width helpers used for the slot index, fail counter and shared timer.
package access_entry_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_GRANT   = 3'd4,
    S_DENY    = 3'd5,
    S_LOCKOUT = 3'd6
  } state_t;

  // Ceiling log2, never less than 1 so a one-slot or one-cycle build still
  // gets a legal vector width.
  function automatic int clog2w(input int value);
    int w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter shared by the GRANT hold, the lockout period and the
// optional entry timeout. load wins over tick; the count parks at zero.
module access_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reload, decrement while non-zero, or hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/access_entry_ctrl.sv
// Access-code entry sequencer. Steps a one-hot load strobe across the digit
// slot registers, compares the assembled code, then grants, denies or locks
// out after repeated failures.
// Build option: define ACCESS_TIMEOUT_EN to abandon a partial entry after
// TIMEOUT_CYCLES cycles without an enter.
module access_entry_ctrl
  import access_entry_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int LOCK_CYCLES    = 250_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          enter,
  input  logic                          clear,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code_in,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] ref_code,
  output logic [NUM_DIGITS-1:0]         load_en,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [clog2w(NUM_DIGITS)-1:0] digit_idx,
  output logic                          grant,
  output logic                          deny,
  output logic                          locked,
  output logic                          busy
);

  localparam int IDX_W   = clog2w(NUM_DIGITS);
  localparam int FAIL_W  = clog2w(MAX_ATTEMPTS + 1);
  localparam int TIMER_W = clog2w(max3(HOLD_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES));

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
`ifdef ACCESS_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [NUM_DIGITS-1:0] load_en_q, load_en_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [FAIL_W-1:0]   fail_inc;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_value;
  logic                tmr_tick;
  logic                tmr_zero;

  assign fail_inc = fail_q + 1'b1;

  access_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .tick_i  (tmr_tick),
    .zero_o  (tmr_zero)
  );

  // Next-state, slot strobe, fail counting and timer control.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    load_en_d = '0;
    fail_d    = fail_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_tick  = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (clear) begin
          // clear beats a simultaneous enter; the digit is dropped.
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (enter) begin
          digit_d   = digit_in;
          load_en_d = NUM_DIGITS'(1) << idx_q;
          if (idx_q == LAST_IDX) begin
            state_d = S_WAIT;
            idx_d   = '0;
          end else begin
            state_d = S_COLLECT;
            idx_d   = idx_q + 1'b1;
          end
`ifdef ACCESS_TIMEOUT_EN
          tmr_load  = 1'b1;
          tmr_value = TIMEOUT_LOAD;
`endif
        end
`ifdef ACCESS_TIMEOUT_EN
        else if (state_q == S_COLLECT) begin
          if (tmr_zero) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            tmr_tick = 1'b1;
          end
        end
`endif
      end
      // Give the slot registers the cycle in which they capture the last digit.
      S_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        if (code_in == ref_code) begin
          state_d   = S_GRANT;
          tmr_load  = 1'b1;
          tmr_value = HOLD_LOAD;
        end else begin
          state_d = S_DENY;
        end
      end
      S_GRANT: begin
        fail_d = '0;
        if (tmr_zero) begin
          state_d = S_IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      S_DENY: begin
        if (fail_inc >= FAIL_MAX) begin
          fail_d    = FAIL_MAX;
          state_d   = S_LOCKOUT;
          tmr_load  = 1'b1;
          tmr_value = LOCK_LOAD;
        end else begin
          fail_d  = fail_inc;
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tmr_zero) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: slot index, held digit, load strobe, fail count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q     <= '0;
      digit_q   <= '0;
      load_en_q <= '0;
      fail_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      load_en_q <= load_en_d;
      fail_q    <= fail_d;
    end
  end

  assign load_en   = load_en_q;
  assign digit_out = digit_q;
  assign digit_idx = idx_q;
  assign grant     = (state_q == S_GRANT);
  assign deny      = (state_q == S_DENY);
  assign locked    = (state_q == S_LOCKOUT);
  assign busy      = (state_q != S_IDLE) && (state_q != S_COLLECT);

endmodule

// File: tb/tb_access_entry_ctrl.sv
// Bench for access_entry_ctrl: directed entries, a cycle-indexed expectation
// timeline built from the entry rules, and literal spot checks.
module tb_access_entry_ctrl;

  localparam int ND   = 4;
  localparam int MAXA = 3;
  localparam int HOLD = 4;
  localparam int LOCK = 8;
  localparam int TOUT = 10;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic [15:0] code_in;
  logic [15:0] ref_code = 16'h4321;
  logic [3:0]  load_en;
  logic [3:0]  digit_out;
  logic [1:0]  digit_idx;
  logic        grant, deny, locked, busy;

  logic [3:0]  slots [4];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Expected outputs per cycle index (cycle k = interval after the k-th rising edge).
  logic [3:0]  e_load [MAXC];
  logic [3:0]  e_dout [MAXC];
  logic [1:0]  e_idx  [MAXC];
  logic        e_grant[MAXC];
  logic        e_deny [MAXC];
  logic        e_lock [MAXC];
  logic        e_busy [MAXC];

  int          m_n, m_fails, m_ready, m_last;
  logic [3:0]  m_digs [4];

  access_entry_ctrl #(
    .NUM_DIGITS     (ND),
    .DIGIT_W        (4),
    .MAX_ATTEMPTS   (MAXA),
    .HOLD_CYCLES    (HOLD),
    .LOCK_CYCLES    (LOCK),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_in  (digit_in),
    .enter     (enter),
    .clear     (clear),
    .code_in   (code_in),
    .ref_code  (ref_code),
    .load_en   (load_en),
    .digit_out (digit_out),
    .digit_idx (digit_idx),
    .grant     (grant),
    .deny      (deny),
    .locked    (locked),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External slot registers driven by the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load_en[i]) slots[i] <= digit_out;
    end
  end
  assign code_in = {slots[3], slots[2], slots[1], slots[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fill_dout(input int from, input logic [3:0] v);
    for (int i = from; i < MAXC; i++) e_dout[i] = v;
  endtask

  task automatic fill_idx(input int from, input logic [1:0] v);
    for (int i = from; i < MAXC; i++) e_idx[i] = v;
  endtask

  // which: 0 grant, 1 deny, 2 locked, 3 busy
  task automatic mark(input int which, input int from, input int to);
    for (int i = from; i <= to && i < MAXC; i++) begin
      case (which)
        0: e_grant[i] = 1'b1;
        1: e_deny[i]  = 1'b1;
        2: e_lock[i]  = 1'b1;
        3: e_busy[i]  = 1'b1;
        default: ;
      endcase
    end
  endtask

  // Inputs present during cycle c take effect from cycle c+1.
  task automatic model_step(input int c, input logic en, input logic [3:0] d, input logic clr);
    logic [15:0] code;
`ifdef ACCESS_TIMEOUT_EN
    if (m_n > 0 && c >= m_last + TOUT + 1) begin
      m_n = 0;
      fill_idx(m_last + TOUT + 1, 2'd0);
    end
`endif
    if (c >= m_ready) begin
      if (clr) begin
        m_n = 0;
        fill_idx(c + 1, 2'd0);
      end else if (en) begin
        if (c + 1 < MAXC) e_load[c + 1] = 4'(1 << m_n);
        fill_dout(c + 1, d);
        m_digs[m_n] = d;
        m_n++;
        m_last = c;
        if (m_n == ND) begin
          m_n = 0;
          fill_idx(c + 1, 2'd0);
          code = {m_digs[3], m_digs[2], m_digs[1], m_digs[0]};
          if (code == ref_code) begin
            mark(0, c + 3, c + 2 + HOLD);
            mark(3, c + 1, c + 2 + HOLD);
            m_fails = 0;
            m_ready = c + 3 + HOLD;
          end else begin
            mark(1, c + 3, c + 3);
            m_fails++;
            if (m_fails == MAXA) begin
              mark(2, c + 4, c + 3 + LOCK);
              mark(3, c + 1, c + 3 + LOCK);
              m_fails = 0;
              m_ready = c + 4 + LOCK;
            end else begin
              mark(3, c + 1, c + 3);
              m_ready = c + 4;
            end
          end
        end else begin
          fill_idx(c + 1, 2'(m_n));
        end
      end
    end
  endtask

  task automatic model_reset(input int c);
    for (int i = c + 1; i < MAXC; i++) begin
      e_load[i] = 4'd0; e_dout[i] = 4'd0; e_idx[i] = 2'd0;
      e_grant[i] = 1'b0; e_deny[i] = 1'b0; e_lock[i] = 1'b0; e_busy[i] = 1'b0;
    end
    m_n = 0;
    m_fails = 0;
    m_ready = c + 1;
  endtask

  task automatic step(input logic en, input logic [3:0] d, input logic clr);
    enter = en;
    digit_in = d;
    clear = clr;
    model_step(cyc, en, d, clr);
    @(posedge clk);
    #1;
    enter = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    $display("reset pulse at cycle %0d", cyc);
    rst = 1'b0;
    model_reset(cyc);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic enter_code(input logic [15:0] code, output int last);
    $display("entry code=%h starting cycle %0d", code, cyc);
    last = cyc;
    for (int i = 0; i < 4; i++) begin
      last = cyc;
      step(1'b1, code[4*i +: 4], 1'b0);
    end
  endtask

  // Per-cycle comparison against the expectation timeline.
  always @(negedge clk) begin
    if (cyc >= 2 && cyc < MAXC) begin
      chk("load_en",   32'(load_en),   32'(e_load[cyc]));
      chk("digit_out", 32'(digit_out), 32'(e_dout[cyc]));
      chk("digit_idx", 32'(digit_idx), 32'(e_idx[cyc]));
      chk("grant",     32'(grant),     32'(e_grant[cyc]));
      chk("deny",      32'(deny),      32'(e_deny[cyc]));
      chk("locked",    32'(locked),    32'(e_lock[cyc]));
      chk("busy",      32'(busy),      32'(e_busy[cyc]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < MAXC; i++) begin
      e_load[i] = 4'd0; e_dout[i] = 4'd0; e_idx[i] = 2'd0;
      e_grant[i] = 1'b0; e_deny[i] = 1'b0; e_lock[i] = 1'b0; e_busy[i] = 1'b0;
    end
    m_n = 0; m_fails = 0; m_ready = 0; m_last = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_idx", 32'(digit_idx), 32'h0);

    // Correct code 1,2,3,4 -> grant for HOLD cycles.
    $display("entry code=4321 digit by digit at cycle %0d", cyc);
    step(1'b1, 4'd1, 1'b0);
    chk("t1_load_slot0", 32'(load_en), 32'h1);
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    c = cyc;
    step(1'b1, 4'd4, 1'b0);
    chk("t1_load_slot3", 32'(load_en), 32'h8);
    idle_until(c + 2);  chk("t1_grant_before", 32'(grant), 32'h0);
    idle_until(c + 3);  chk("t1_grant_rise", 32'(grant), 32'h1);
    idle_until(c + 6);  chk("t1_grant_last", 32'(grant), 32'h1);
    idle_until(c + 7);  chk("t1_grant_fall", 32'(grant), 32'h0);
    chk("t1_idx_zero", 32'(digit_idx), 32'h0);

    // Wrong code -> one deny pulse, no lockout.
    enter_code(16'h5321, c);
    idle_until(c + 3);  chk("t2_deny", 32'(deny), 32'h1);
    idle_until(c + 4);  chk("t2_deny_end", 32'(deny), 32'h0);
    chk("t2_not_locked", 32'(locked), 32'h0);

    // clear+enter together drops the digit; fail count survives clear.
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b1);
    chk("t4_clear_no_load", 32'(load_en), 32'h0);
    chk("t4_clear_idx", 32'(digit_idx), 32'h0);
    step(1'b1, 4'd6, 1'b0);
    chk("t4_restart_slot0", 32'(load_en), 32'h1);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    idle_until(m_ready);
    enter_code(16'h0000, c);
    idle_until(c + 4);  chk("t4_fail_kept_lock", 32'(locked), 32'h1);
    idle_until(m_ready);

    // Three wrong codes -> lockout; enters ignored; then a correct code grants.
    enter_code(16'h1111, c); idle_until(m_ready);
    enter_code(16'h2222, c); idle_until(m_ready);
    enter_code(16'h3333, c);
    idle_until(c + 3);  chk("t3_third_deny", 32'(deny), 32'h1);
    idle_until(c + 4);  chk("t3_locked", 32'(locked), 32'h1);
    step(1'b1, 4'd3, 1'b0);
    chk("t3_no_load_in_lock", 32'(load_en), 32'h0);
    idle_until(c + 11); chk("t3_locked_last", 32'(locked), 32'h1);
    idle_until(c + 12); chk("t3_unlocked", 32'(locked), 32'h0);
    chk("t3_not_busy", 32'(busy), 32'h0);
    enter_code(16'h4321, c);
    idle_until(c + 3);  chk("t3_grant_after_lock", 32'(grant), 32'h1);
    idle_until(m_ready);

    // Reset during the second GRANT cycle.
    enter_code(16'h4321, c);
    idle_until(c + 4);
    do_reset();
    chk("t5_grant_cleared", 32'(grant), 32'h0);
    chk("t5_busy_cleared", 32'(busy), 32'h0);
    chk("t5_dout_cleared", 32'(digit_out), 32'h0);
    chk("t5_idx_cleared", 32'(digit_idx), 32'h0);

    // Reset also clears the fail count.
    enter_code(16'h9999, c); idle_until(m_ready);
    enter_code(16'h8888, c); idle_until(m_ready);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    do_reset();
    enter_code(16'h7777, c); idle_until(m_ready);
    enter_code(16'h6666, c);
    idle_until(c + 4);  chk("t5_fail_reset", 32'(locked), 32'h0);
    idle_until(m_ready);

`ifdef ACCESS_TIMEOUT_EN
    // Partial entry abandoned after TOUT idle cycles, without a deny.
    $display("timeout entry at cycle %0d", cyc);
    c = cyc;
    step(1'b1, 4'd1, 1'b0);
    idle_until(c + 10); chk("t6_still_collect", 32'(digit_idx), 32'h1);
    idle_until(c + 11); chk("t6_timeout_idx", 32'(digit_idx), 32'h0);
    chk("t6_no_deny", 32'(deny), 32'h0);
    enter_code(16'h4321, c);
    idle_until(c + 3);  chk("t6_grant_after", 32'(grant), 32'h1);
    idle_until(m_ready);
`endif

    idle_until(cyc + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
